idct8_serial: RTL and testbench
===============================

// Module: idct8_serial
// PURPOSE
//  8-point integer inverse DCT, the inverse of the serial forward DCT in the compression datapath.
//  Accepts 8 coefficients X0..X7 serially, one per accepted beat.
//  Emits 8 reconstructed samples x0..x7 serially, in lockstep with the next block's input beats.
//  Sits in the decode/verify path after dequantisation.
// PARAMETERS
//  BITS   25  signed width of the coefficient input and the sample output
//  SHIFT  13  arithmetic right shift applied to the raw result when IDCT_NORM_EN is undefined
// PORTS
//  clk          in   1     clock
//  rst          in   1     reset, synchronous, active-high
//  in_valid     in   1     coefficient on `in` is valid this cycle (one beat)
//  in           in   BITS  signed coefficient Xk, k = beat index 0..7
//  out_valid    out  1     O carries a valid sample this cycle
//  frame_start  out  1     O carries x0 of a block (first output beat)
//  O            out  BITS  signed reconstructed sample xk
// BEHAVIOUR
//  Reset (rst=1 at posedge clk): the following clear to 0.
//    - k counter (3 bit), coef regs[0..7], out buffer[0..7], O, out_valid, frame_start, primed flag.
//    - A partial block in progress is discarded.
//  Beat = posedge with in_valid=1. On each beat:
//    - coef[k] <= in; k <= k+1, wrapping 7 -> 0.
//    - O <= buffer_next[k], where buffer_next = transform(coef) when k==0, else buffer.
//    - When k==0, buffer <= transform(coef), with coef holding the previous complete block (pre-edge value).
//    - out_valid <= primed; frame_start <= primed & (k==0).
//  primed is set on the beat where k==7, and stays set until reset.
//  The first block after reset therefore produces no valid output.
//  No beat (in_valid=0): k, coef, buffer and O hold; out_valid <= 0; frame_start <= 0.
//  Latency: xj of block n appears on O one cycle after beat j of block n+1.
//  Stalls between beats are permitted anywhere, including mid-block. Back-to-back blocks need no idle cycle.
//  Transform (all signed, internal width BITS+10, no intermediate truncation):
//    - w0=39X0; w1=39X4; w2=36X2-15X6; w3=15X2+36X6
//    - w4=35X1-14X3+8X5-6X7;  w5=-2X1+19X3+30X5-16X7
//    - w6=16X1+30X3-19X5-2X7; w7=6X1+8X3+14X5+35X7
//    - b0=w0+w2 b2=w0-w2 b4=w1+w3 b6=w3-w1 b1=w4+w6 b3=w4-w6 b5=w5+w7 b7=w7-w5
//    - a0=b0+b4 a1=b0-b4 a2=b2+b6 a3=b2-b6 a4=b1+b5 a5=b1-b5 a6=b3+b7 a7=b3-b7
//    - r0=a0+a4 r7=a0-a4 r1=a1+a5 r6=a1-a5 r2=a2+a6 r5=a2-a6 r3=a3+a7 r4=a3-a7
//  Scaling: the round-trip gain of the forward and inverse transforms is 1521*8 = 12168.
//  Each rj is scaled (see CONFIGURATION), then saturated to the signed BITS range.
// CONFIGURATION
//  IDCT_NORM_EN defined: xj = (rj*43 + 2^18) >>> 19, i.e. normalised with round-half-up (gain error ~0.2%).
//  IDCT_NORM_EN undefined: xj = rj >>> SHIFT, i.e. floor, unnormalised gain ~1.485 at SHIFT=13.
//  Saturation and timing are identical in both builds.
// STRUCTURE
//  idct_pkg:
//    - coefficient constants C39,C36,C15,C35,C2,C8,C30,C16,C6,C19,C14
//    - NORM_MUL=43, NORM_SHIFT=19, INT_W=BITS+10
//    - saturate function
//  idct8_core sub-module: purely combinational transform, coef[8] -> x[8] including scaling and saturation.
//  idct8_serial top: beat counter, coef and out buffers, primed/valid logic.
// TESTING
//  1 Reset, then 8 beats of X=0 followed by a 2nd block -> out_valid=0 during block 1; then 8 valid zeros, frame_start on beat 0 only.
//  2 DC: block X0=4096, rest 0, followed by any block -> all eight O=13 (NORM_EN) / 19 (no NORM_EN).
//  3 Negative DC: X0=-4096 -> all O=-13 (NORM_EN) / -20 (no NORM_EN).
//  4 Round trip: constant-1 input through forward DCT gives X0=312, rest 0 -> all O=1 (NORM_EN).
//  5 Stalls: random in_valid gaps mid-block -> same O sequence as the gap-free run; out_valid only on beats; O held during gaps.
//  6 rst asserted after beat 4 -> all outputs 0 next cycle; the next block is treated as the first block (no valid output); X0=+max at full scale saturates to 2^(BITS-1)-1.

Source files
------------

// File: rtl/idct_pkg.sv
// Shared constants and helpers for the 8-point serial inverse DCT.
package idct_pkg;

  localparam int DEF_BITS  = 25;
  localparam int DEF_SHIFT = 13;
  localparam int INT_W     = DEF_BITS + 10;

  localparam int C39 = 39;
  localparam int C36 = 36;
  localparam int C15 = 15;
  localparam int C35 = 35;
  localparam int C2  = 2;
  localparam int C8  = 8;
  localparam int C30 = 30;
  localparam int C16 = 16;
  localparam int C6  = 6;
  localparam int C19 = 19;
  localparam int C14 = 14;

  localparam int NORM_MUL   = 43;
  localparam int NORM_SHIFT = 19;

  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int bits);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (bits - 1));
    if (v > hi)      saturate = hi;
    else if (v < lo) saturate = lo;
    else             saturate = v;
  endfunction

endpackage

// File: rtl/idct8_core.sv
// Combinational 8-point inverse DCT butterfly with scaling and saturation.
// Build option IDCT_NORM_EN: round-half-up normalisation by 43/2^19 instead of a plain floor shift.
module idct8_core
  import idct_pkg::*;
#(
  parameter int BITS  = DEF_BITS,
  parameter int SHIFT = DEF_SHIFT
) (
  input  logic signed [BITS-1:0] coef [8],
  output logic signed [BITS-1:0] x    [8]
);

  localparam int IW = BITS + 10;

  logic signed [IW-1:0] xc [8];
  logic signed [IW-1:0] w  [8];
  logic signed [IW-1:0] b  [8];
  logic signed [IW-1:0] a  [8];
  logic signed [IW-1:0] r  [8];
  logic signed [63:0]   s  [8];

  function automatic logic signed [IW-1:0] m(input int c, input logic signed [IW-1:0] v);
    return IW'(c) * v;
  endfunction

  always_comb begin
    for (int i = 0; i < 8; i++) xc[i] = IW'(coef[i]);

    w[0] = m(C39, xc[0]);
    w[1] = m(C39, xc[4]);
    w[2] = m(C36, xc[2]) - m(C15, xc[6]);
    w[3] = m(C15, xc[2]) + m(C36, xc[6]);
    w[4] = m(C35, xc[1]) - m(C14, xc[3]) + m(C8,  xc[5]) - m(C6,  xc[7]);
    w[5] = m(C19, xc[3]) - m(C2,  xc[1]) + m(C30, xc[5]) - m(C16, xc[7]);
    w[6] = m(C16, xc[1]) + m(C30, xc[3]) - m(C19, xc[5]) - m(C2,  xc[7]);
    w[7] = m(C6,  xc[1]) + m(C8,  xc[3]) + m(C14, xc[5]) + m(C35, xc[7]);

    b[0] = w[0] + w[2];  b[2] = w[0] - w[2];
    b[4] = w[1] + w[3];  b[6] = w[3] - w[1];
    b[1] = w[4] + w[6];  b[3] = w[4] - w[6];
    b[5] = w[5] + w[7];  b[7] = w[7] - w[5];

    a[0] = b[0] + b[4];  a[1] = b[0] - b[4];
    a[2] = b[2] + b[6];  a[3] = b[2] - b[6];
    a[4] = b[1] + b[5];  a[5] = b[1] - b[5];
    a[6] = b[3] + b[7];  a[7] = b[3] - b[7];

    r[0] = a[0] + a[4];  r[7] = a[0] - a[4];
    r[1] = a[1] + a[5];  r[6] = a[1] - a[5];
    r[2] = a[2] + a[6];  r[5] = a[2] - a[6];
    r[3] = a[3] + a[7];  r[4] = a[3] - a[7];

    // scaling is done at 64 bits so the normalising multiply cannot overflow
    for (int j = 0; j < 8; j++) begin
`ifdef IDCT_NORM_EN
      s[j] = (64'(r[j]) * 64'(NORM_MUL) + (64'sd1 <<< (NORM_SHIFT - 1))) >>> NORM_SHIFT;
`else
      s[j] = 64'(r[j]) >>> SHIFT;
`endif
      x[j] = BITS'(saturate(s[j], BITS));
    end
  end

endmodule

// File: rtl/idct8_serial.sv
// Serial 8-point inverse DCT: one coefficient in and one sample out per beat,
// output of block n is emitted in lockstep with the beats of block n+1.
module idct8_serial
  import idct_pkg::*;
#(
  parameter int BITS  = DEF_BITS,
  parameter int SHIFT = DEF_SHIFT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic signed [BITS-1:0] in,
  output logic                   out_valid,
  output logic                   frame_start,
  output logic signed [BITS-1:0] O
);

  logic [2:0]             k;
  logic                   primed;
  logic signed [BITS-1:0] coef  [8];
  logic signed [BITS-1:0] obuf  [8];
  logic signed [BITS-1:0] xform [8];

  idct8_core #(.BITS(BITS), .SHIFT(SHIFT)) u_core (
    .coef (coef),
    .x    (xform)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      k           <= '0;
      primed      <= 1'b0;
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
      O           <= '0;
      for (int i = 0; i < 8; i++) begin
        coef[i] <= '0;
        obuf[i] <= '0;
      end
    end else if (in_valid) begin
      coef[k]     <= in;
      k           <= k + 3'd1;
      out_valid   <= primed;
      frame_start <= primed && (k == 3'd0);
      // k==0: coef still holds the previous complete block, so latch its transform
      if (k == 3'd0) begin
        O <= xform[0];
        for (int i = 0; i < 8; i++) obuf[i] <= xform[i];
      end else begin
        O <= obuf[k];
      end
      if (k == 3'd7) primed <= 1'b1;
    end else begin
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_idct8_serial.sv
// Scoreboard bench for idct8_serial: directed blocks with hand-computed samples for either build.
module tb_idct8_serial;

  typedef int vec_t [8];
  typedef struct {
    int val;
    bit fs;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic signed [24:0] in_d = '0;
  logic               out_valid;
  logic               frame_start;
  logic signed [24:0] O;

  always #5 clk = ~clk;

  idct8_serial #(.BITS(25), .SHIFT(13)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in          (in_d),
    .out_valid   (out_valid),
    .frame_start (frame_start),
    .O           (O)
  );

  localparam vec_t V_ZERO = '{0, 0, 0, 0, 0, 0, 0, 0};
  localparam vec_t V_DC   = '{4096, 0, 0, 0, 0, 0, 0, 0};
  localparam vec_t V_NDC  = '{-4096, 0, 0, 0, 0, 0, 0, 0};
  localparam vec_t V_ONE  = '{312, 0, 0, 0, 0, 0, 0, 0};
  localparam vec_t V_X1   = '{0, 4096, 0, 0, 0, 0, 0, 0};
  localparam vec_t V_X2   = '{0, 0, 4096, 0, 0, 0, 0, 0};
  localparam vec_t V_MAX  = '{16777215, 0, 0, 0, 0, 0, 0, 0};

  localparam vec_t E_ZERO = '{0, 0, 0, 0, 0, 0, 0, 0};
  localparam vec_t E_ONE  = '{1, 1, 1, 1, 1, 1, 1, 1};
`ifdef IDCT_NORM_EN
  localparam vec_t E_DC   = '{13, 13, 13, 13, 13, 13, 13, 13};
  localparam vec_t E_NDC  = '{-13, -13, -13, -13, -13, -13, -13, -13};
  localparam vec_t E_X1   = '{18, 16, 9, 4, -4, -9, -16, -18};
  localparam vec_t E_X2   = '{17, 7, -7, -17, -17, -7, 7, 17};
  localparam vec_t E_MAX  = '{53664, 53664, 53664, 53664, 53664, 53664, 53664, 53664};
`else
  localparam vec_t E_DC   = '{19, 19, 19, 19, 19, 19, 19, 19};
  localparam vec_t E_NDC  = '{-20, -20, -20, -20, -20, -20, -20, -20};
  localparam vec_t E_X1   = '{27, 23, 13, 5, -6, -14, -24, -28};
  localparam vec_t E_X2   = '{25, 10, -11, -26, -26, -11, 10, 25};
  localparam vec_t E_MAX  = '{79871, 79871, 79871, 79871, 79871, 79871, 79871, 79871};
`endif

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  vec_t pending;
  bit   have_pending = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(input int x);
    in_valid = 1'b1;
    in_d     = 25'(x);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // The previous block's samples come out during this block's beats.
  task automatic send_block(input vec_t xs, input vec_t ex, input bit stall, input int nbeats);
    if (have_pending)
      for (int j = 0; j < 8; j++) q.push_back('{pending[j], j == 0});
    pending      = ex;
    have_pending = 1'b1;
    for (int j = 0; j < nbeats; j++) begin
      if (stall) idle($urandom_range(0, 3));
      beat(xs[j]);
    end
  endtask

  logic last_beat = 1'b0;
  logic last_rst  = 1'b1;
  int   o_prev    = 0;

  always @(posedge clk) begin
    last_beat <= in_valid && !rst;
    last_rst  <= rst;
  end

  always @(negedge clk) begin
    if (!last_rst) begin
      if (out_valid) begin
        check("valid_only_on_beat", int'(last_beat), 1);
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got O=%0d with out_valid=1, required no output", O);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("sample", int'(O), e.val);
          check("frame_start", int'(frame_start), int'(e.fs));
        end
      end else begin
        check("frame_start_idle", int'(frame_start), 0);
        if (!last_beat) check("hold_O", int'(O), o_prev);
      end
    end
    o_prev = int'(O);
  end

  initial begin
    idle(3);
    check("rst_O", int'(O), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_frame_start", int'(frame_start), 0);
    rst = 1'b0;
    idle(2);

    send_block(V_ZERO, E_ZERO, 1'b0, 8);
    send_block(V_DC,   E_DC,   1'b0, 8);
    send_block(V_NDC,  E_NDC,  1'b0, 8);
    send_block(V_ONE,  E_ONE,  1'b0, 8);
    send_block(V_X1,   E_X1,   1'b0, 8);
    send_block(V_X2,   E_X2,   1'b0, 8);
    idle(2);
    send_block(V_X1,   E_X1,   1'b1, 8);
    send_block(V_X2,   E_X2,   1'b1, 8);
    send_block(V_DC,   E_DC,   1'b1, 8);
    send_block(V_ZERO, E_ZERO, 1'b0, 8);

    // abort a block after beat 4
    send_block(V_X1, E_X1, 1'b0, 5);
    rst = 1'b1;
    idle(1);
    check("midrst_O", int'(O), 0);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_frame_start", int'(frame_start), 0);
    q.delete();
    have_pending = 1'b0;
    rst = 1'b0;
    idle(1);

    send_block(V_MAX,  E_MAX,  1'b0, 8);
    send_block(V_ZERO, E_ZERO, 1'b0, 8);
    idle(3);
    check("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
